// File: rtl/map_arbiter_if.sv
// map_arbiter_if: requester-side handshake and map RAM port bundle for map_arbiter
interface map_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    we;
    logic [NUM_REQ*10-1:0] req_x;
    logic [NUM_REQ*10-1:0] req_y;
    logic [NUM_REQ*4-1:0]  req_wdata;
    logic [NUM_REQ-1:0]    ack;
    logic [NUM_REQ-1:0]    rvalid;
    logic [3:0]            rdata;
    logic                  busy;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_wdata;
    logic [3:0]            mem_rdata;

    modport slave (
        input  req, we, req_x, req_y, req_wdata, mem_rdata,
        output ack, rvalid, rdata, busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, we, req_x, req_y, req_wdata, mem_rdata,
        input  ack, rvalid, rdata, busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/map_arbiter.sv
// map_arbiter: round-robin sharing of the single-port map RAM; define MAP_CLEAR_EN to zero the map after reset
module map_arbiter #(
    parameter int MAPA_WIDTH  = 32,
    parameter int MAPA_HEIGHT = 24,
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    map_arbiter_if.slave  ifc
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam logic [9:0] W_C = 10'(MAPA_WIDTH);
    localparam logic [9:0] H_C = 10'(MAPA_HEIGHT);
`ifdef MAP_CLEAR_EN
    localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(MAPA_WIDTH * MAPA_HEIGHT);
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
`ifdef MAP_CLEAR_EN
        CLEAR,
`endif
        RD_WAIT
    } state_t;

`ifdef MAP_CLEAR_EN
    localparam state_t RST_ST = CLEAR;
`else
    localparam state_t RST_ST = IDLE;
`endif

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        win_q, win_d;
    logic                 wr_q, wr_d;
    logic                 oor_q, oor_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
    logic [3:0]           rdata_q, rdata_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d;
    logic [3:0]           mem_wdata_q, mem_wdata_d;
`ifdef MAP_CLEAR_EN
    logic [ADDR_W:0]      cnt_q, cnt_d;
    logic                 busy_q, busy_d;
`endif

    logic [PW-1:0]        win;
    logic [PW-1:0]        idx;
    logic [9:0]           sel_x;
    logic [9:0]           sel_y;
    logic                 sel_oor;
    logic [ADDR_W-1:0]    sel_addr;

    // Round-robin pick: the lowest offset from ptr with req set wins, so scan offsets high to low
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (ifc.req[idx]) win = idx;
        end
    end

    assign sel_x    = ifc.req_x[10*int'(win) +: 10];
    assign sel_y    = ifc.req_y[10*int'(win) +: 10];
    assign sel_oor  = (sel_x >= W_C) || (sel_y >= H_C);
    assign sel_addr = ADDR_W'(sel_y) * ADDR_W'(MAPA_WIDTH) + ADDR_W'(sel_x);

    // Next-state and registered-output computation; ack/rvalid/mem_we are single-cycle pulses
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        wr_d        = wr_q;
        oor_d       = oor_q;
        ack_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
`ifdef MAP_CLEAR_EN
        cnt_d       = cnt_q;
        busy_d      = busy_q;
`endif
        case (state_q)
            IDLE: begin
                if (|ifc.req) begin
                    state_d     = ACCESS;
                    win_d       = win;
                    ptr_d       = PW'((int'(win) + 1) % NUM_REQ);
                    wr_d        = ifc.we[win];
                    oor_d       = sel_oor;
                    ack_d       = NUM_REQ'(1) << win;
                    mem_addr_d  = sel_oor ? '0 : sel_addr;
                    mem_we_d    = ifc.we[win] && !sel_oor;
                    mem_wdata_d = ifc.req_wdata[4*int'(win) +: 4];
                end
            end
            ACCESS: state_d = wr_q ? IDLE : RD_WAIT;
            RD_WAIT: begin
                rdata_d  = oor_q ? 4'b0001 : ifc.mem_rdata;
                rvalid_d = NUM_REQ'(1) << win_q;
                state_d  = IDLE;
            end
`ifdef MAP_CLEAR_EN
            CLEAR: begin
                if (cnt_q == CELLS) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    busy_d      = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = '0;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    cnt_d       = cnt_q + (ADDR_W+1)'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_ST;
            ptr_q       <= '0;
            win_q       <= '0;
            wr_q        <= 1'b0;
            oor_q       <= 1'b0;
            ack_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
`ifdef MAP_CLEAR_EN
            cnt_q       <= '0;
            busy_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            wr_q        <= wr_d;
            oor_q       <= oor_d;
            ack_q       <= ack_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MAP_CLEAR_EN
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
`endif
        end
    end

    assign ifc.ack       = ack_q;
    assign ifc.rvalid    = rvalid_q;
    assign ifc.rdata     = rdata_q;
    assign ifc.mem_addr  = mem_addr_q;
    assign ifc.mem_we    = mem_we_q;
    assign ifc.mem_wdata = mem_wdata_q;
`ifdef MAP_CLEAR_EN
    assign ifc.busy      = busy_q;
`else
    assign ifc.busy      = 1'b0;
`endif
endmodule

// File: tb/tb_map_arbiter.sv
// tb_map_arbiter: directed checks of map_arbiter on a 4x3 map with a behavioural sync-read RAM
module tb_map_arbiter;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NR = 3;
    localparam int AW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    map_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) ifc ();

    map_arbiter #(
        .MAPA_WIDTH (W),
        .MAPA_HEIGHT(H),
        .NUM_REQ    (NR),
        .ADDR_W     (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ifc  (ifc)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]    ram [0:1023] = '{default: 4'h0};
    logic          pre_we   = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [3:0]    pre_data = '0;

    // Sync-read RAM, one cycle latency; bench preload port takes priority
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
        ifc.mem_rdata <= ram[ifc.mem_addr];
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic r, logic w, int x, int y, logic [3:0] d);
        ifc.req[i]            = r;
        ifc.we[i]             = w;
        ifc.req_x[10*i +: 10] = 10'(x);
        ifc.req_y[10*i +: 10] = 10'(y);
        ifc.req_wdata[4*i +: 4] = d;
    endtask

    task automatic preload(int a, logic [3:0] d);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
`ifdef MAP_CLEAR_EN
        repeat (14) tick();
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        release_rst();
    endtask

    int exp_ack [4] = '{1, 2, 4, 1};
    int exp_rd  [3] = '{3, 5, 7};

    initial begin
        int ga;
        int gr;
        int nb;
        int seen;
        ifc.req       = '0;
        ifc.we        = '0;
        ifc.req_x     = '0;
        ifc.req_y     = '0;
        ifc.req_wdata = '0;
        #1 rst_n = 1'b0;
        tick();
        check("rst_ack",    32'(ifc.ack), 0);
        check("rst_rvalid", 32'(ifc.rvalid), 0);
        check("rst_rdata",  32'(ifc.rdata), 0);
        check("rst_busy",   32'(ifc.busy), 0);
        check("rst_we",     32'(ifc.mem_we), 0);
        check("rst_addr",   32'(ifc.mem_addr), 0);
        check("rst_wdata",  32'(ifc.mem_wdata), 0);
        release_rst();

        // 1: write (2,1)=A then read it back
        set_req(0, 1, 1, 2, 1, 4'hA);
        tick();
        check("t1_ack",   32'(ifc.ack), 1);
        check("t1_addr",  32'(ifc.mem_addr), 6);
        check("t1_we",    32'(ifc.mem_we), 1);
        check("t1_wdata", 32'(ifc.mem_wdata), 4'hA);
        set_req(0, 1, 0, 2, 1, 4'h0);
        tick();
        check("t1_ack_gap", 32'(ifc.ack), 0);
        check("t1_we_gap",  32'(ifc.mem_we), 0);
        tick();
        check("t1_rd_ack",  32'(ifc.ack), 1);
        check("t1_rd_we",   32'(ifc.mem_we), 0);
        check("t1_rd_addr", 32'(ifc.mem_addr), 6);
        set_req(0, 0, 0, 0, 0, 4'h0);
        tick();
        check("t1_rv_early", 32'(ifc.rvalid), 0);
        tick();
        check("t1_rvalid", 32'(ifc.rvalid), 1);
        check("t1_rdata",  32'(ifc.rdata), 4'hA);
        tick();
        check("t1_rv_pulse", 32'(ifc.rvalid), 0);

        // 2: all three reading continuously after reset; round-robin from 0
        do_reset();
        preload(0, 4'h3);
        preload(1, 4'h5);
        preload(2, 4'h7);
        preload(4, 4'h2);
        preload(11, 4'h9);
        set_req(0, 1, 0, 0, 0, 4'h0);
        set_req(1, 1, 0, 1, 0, 4'h0);
        set_req(2, 1, 0, 2, 0, 4'h0);
        ga = 0;
        gr = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("t2_ack_1hot", 32'($onehot0(ifc.ack)), 1);
            check("t2_rv_1hot",  32'($onehot0(ifc.rvalid)), 1);
            if (ifc.ack != 0 && ga < 4) begin
                check($sformatf("t2_ack%0d", ga), 32'(ifc.ack), exp_ack[ga]);
                ga++;
            end
            if (ifc.rvalid != 0 && gr < 3) begin
                check($sformatf("t2_rv%0d", gr), 32'(ifc.rvalid), exp_ack[gr]);
                check($sformatf("t2_rd%0d", gr), 32'(ifc.rdata), exp_rd[gr]);
                gr++;
            end
        end
        check("t2_grants",  ga, 4);
        check("t2_rvalids", gr, 3);
        ifc.req = '0;
        repeat (3) tick();

        // 3: out-of-range write/read, last-cell boundary, back-to-back writes
        set_req(1, 1, 1, 4, 0, 4'hF);
        tick();
        check("t3_oor_ack", 32'(ifc.ack), 2);
        check("t3_oor_we",  32'(ifc.mem_we), 0);
        set_req(1, 0, 0, 0, 0, 4'h0);
        tick();
        check("t3_ram0", 32'(ram[0]), 3);
        check("t3_ram4", 32'(ram[4]), 2);
        set_req(1, 1, 0, 0, 3, 4'h0);
        tick();
        check("t3_oorrd_ack", 32'(ifc.ack), 2);
        set_req(1, 0, 0, 0, 0, 4'h0);
        tick();
        tick();
        check("t3_oorrd_rv", 32'(ifc.rvalid), 2);
        check("t3_oorrd_rd", 32'(ifc.rdata), 1);
        set_req(1, 1, 0, 3, 2, 4'h0);
        tick();
        check("t3_last_addr", 32'(ifc.mem_addr), 11);
        set_req(1, 0, 0, 0, 0, 4'h0);
        tick();
        tick();
        check("t3_last_rd", 32'(ifc.rdata), 9);
        set_req(2, 1, 1, 3, 2, 4'hC);
        tick();
        check("t3_b2b_ack0", 32'(ifc.ack), 4);
        check("t3_b2b_we0",  32'(ifc.mem_we), 1);
        check("t3_b2b_wd0",  32'(ifc.mem_wdata), 4'hC);
        tick();
        check("t3_b2b_gap", 32'(ifc.ack), 0);
        tick();
        check("t3_b2b_ack1", 32'(ifc.ack), 4);
        set_req(2, 0, 0, 0, 0, 4'h0);
        tick();
        check("t3_ram11", 32'(ram[11]), 4'hC);

        // 4: reset in RD_WAIT drops the pending read
        set_req(0, 1, 0, 2, 1, 4'h0);
        tick();
        check("t4_ack", 32'(ifc.ack), 1);
        set_req(0, 0, 0, 0, 0, 4'h0);
        tick();
        rst_n = 1'b0;
        #1;
        check("t4_rst_rdata",  32'(ifc.rdata), 0);
        check("t4_rst_addr",   32'(ifc.mem_addr), 0);
        check("t4_rst_rvalid", 32'(ifc.rvalid), 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t4_no_rvalid", 32'(ifc.rvalid), 0);
            check("t4_no_ack",    32'(ifc.ack), 0);
        end

        // 5: first arbitration after reset release
        rst_n = 1'b0;
        preload(5, 4'hF);
        set_req(0, 1, 1, 1, 0, 4'h5);
        tick();
        rst_n = 1'b1;
`ifdef MAP_CLEAR_EN
        nb   = 0;
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (ifc.busy) begin
                nb++;
                check("t5_ack_in_busy", 32'(ifc.ack), 0);
            end
            if (ifc.ack == 1) seen = 1;
        end
        check("t5_busy_len", nb, 12);
        check("t5_ack_after", seen, 1);
        check("t5_ram5", 32'(ram[5]), 0);
`else
        nb   = 0;
        seen = 0;
        check("t5_busy0", 32'(ifc.busy), 0);
        tick();
        check("t5_ack",  32'(ifc.ack), 1);
        check("t5_addr", 32'(ifc.mem_addr), 1);
        check("t5_busy", 32'(ifc.busy), 0);
`endif
        set_req(0, 0, 0, 0, 0, 4'h0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
